seq_mult_unit: RTL and testbench

//  Iterative shift-add WIDTHxWIDTH -> 2*WIDTH multiplier for the execute stage. Responds to the

---
 rtl/seq_mult_unit.sv | 156 +++++++++++++++
 tb/tb_seq_mult_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_unit
// Description : Iterative shift-add WIDTH x WIDTH -> 2*WIDTH multiplier for
//               the execute stage. Operands are latched on an accepted start,
//               one multiplier bit is retired per cycle, and the product is
//               returned on hi/lo together with a one-cycle done pulse. The
//               result is held until the next operation completes.
//
// Ports       : clk    - clock, rising edge
//               rst    - reset, asynchronous, active-high
//               start  - request, sampled while IDLE or DONE
//               sgn    - signed (two's complement) operands, sampled with start
//               flush  - abort any in-flight operation; beats start
//               src_a  - multiplicand, sampled with start
//               src_b  - multiplier, sampled with start
//               busy   - high while an operation is iterating
//               done   - one-cycle pulse, hi/lo valid from this cycle on
//               hi/lo  - upper/lower halves of the product
//
// Config      : MULT_SIGNED_EN - when defined, sgn is honoured (operands are
//               converted to magnitudes and the product sign-corrected).
//               When undefined, sgn is ignored and all operations are
//               unsigned; the magnitude/negate logic is not built.
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(WIDTH - 1);

    localparam logic [1:0]      c_ST_IDLE = 2'd0;
    localparam logic [1:0]      c_ST_BUSY = 2'd1;
    localparam logic [1:0]      c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_accHi;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_result;

    // One shift-add step: conditional add keeps its carry, which becomes the
    // top bit of the right-shifted {carry, accHi, mplier} chain. After the
    // last step the full product is {sum, mplier[WIDTH-1:1]}.
    assign w_sum  = {1'b0, r_accHi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod = {w_sum, r_mplier[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic w_negA;
    logic w_negB;
    logic r_neg;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    assign w_negA   = sgn & src_a[WIDTH-1];
    assign w_negB   = sgn & src_b[WIDTH-1];
    assign w_magA   = w_negA ? -src_a : src_a;
    assign w_magB   = w_negB ? -src_b : src_b;
    assign w_result = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if ((r_state != c_ST_BUSY) && start && !flush) begin
            r_neg <= w_negA ^ w_negB;
        end
    end
`else
    logic w_unusedSgn;

    assign w_unusedSgn = sgn;
    assign w_magA      = src_a;
    assign w_magB      = src_b;
    assign w_result    = w_prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_accHi  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_ST_BUSY: begin
                    if (flush) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_accHi  <= w_sum[WIDTH:1];
                        r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                        if (r_count == c_LAST) begin
                            {r_hi, r_lo} <= w_result;
                            r_state      <= c_ST_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; done drops
                    // after its single cycle regardless.
                    r_done <= 1'b0;
                    if (start && !flush) begin
                        r_mcand  <= w_magA;
                        r_mplier <= w_magB;
                        r_accHi  <= '0;
                        r_count  <= '0;
                        r_state  <= c_ST_BUSY;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_unit
// Description : Directed self-checking bench for seq_mult_unit (WIDTH=32).
//               Inputs change on the falling edge; outputs are sampled on
//               the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

    localparam int c_W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           sgn;
    logic           flush;
    logic [c_W-1:0] src_a;
    logic [c_W-1:0] src_b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    int nChecks;
    int nErrors;
    int nCyc;
    logic sawDone;

    seq_mult_unit #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .flush (flush),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a one-cycle start and returns at the falling edge of the
    // first BUSY cycle.
    task automatic issue(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic s);
        src_a = a;
        src_b = b;
        sgn   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen, bounded.
    task automatic waitDone(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Watches n cycles for any done pulse.
    task automatic watchNoDone(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        flush = 1'b0;
        src_a = '0;
        src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_prod", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5 unsigned: busy immediately, done exactly 32 cycles after start edge
        issue(32'd3, 32'd5, 1'b0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        waitDone(nCyc);
        chk("t1_latency", 64'(nCyc), 64'd32);
        chk("t1_prod", {hi, lo}, 64'h00000000_0000000F);
        @(negedge clk);
        chk("t1_done_pulse", {62'd0, done, busy}, 64'd0);
        chk("t1_hold", {hi, lo}, 64'h00000000_0000000F);

        // max unsigned operands
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        waitDone(nCyc);
        chk("t2_latency", 64'(nCyc), 64'd32);
        chk("t2_prod", {hi, lo}, 64'hFFFFFFFE_00000001);

        // -3 x 5 with sgn set
        @(negedge clk);
        issue(32'hFFFFFFFD, 32'd5, 1'b1);
        waitDone(nCyc);
`ifdef MULT_SIGNED_EN
        chk("t3_neg3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
`else
        chk("t3_neg3x5", {hi, lo}, 64'h00000004_FFFFFFF1);
`endif

        // most-negative squared: 2^62 both signed and unsigned
        @(negedge clk);
        issue(32'h80000000, 32'h80000000, 1'b1);
        waitDone(nCyc);
        chk("t3_minsq", {hi, lo}, 64'h40000000_00000000);

        // zero operand still takes the full latency
        @(negedge clk);
        issue(32'd0, 32'h12345678, 1'b0);
        waitDone(nCyc);
        chk("t3_zero_latency", 64'(nCyc), 64'd32);
        chk("t3_zero_prod", {hi, lo}, 64'd0);

        // flush mid-operation: prior result from 3 x 5 is preserved
        @(negedge clk);
        issue(32'd3, 32'd5, 1'b0);
        waitDone(nCyc);
        @(negedge clk);
        issue(32'd7, 32'd9, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_flush_busy", {63'd0, busy}, 64'd0);
        watchNoDone(40, sawDone);
        chk("t4_no_done", {63'd0, sawDone}, 64'd0);
        chk("t4_hold", {hi, lo}, 64'h00000000_0000000F);

        // flush and start together: nothing starts
        src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("t4_flush_wins", {63'd0, busy}, 64'd0);

        // start while busy is ignored; start in DONE is accepted
        issue(32'd2, 32'd2, 1'b0);
        nCyc = 0;
        while (!done && nCyc < 100) begin
            if (nCyc == 4) begin
                src_a = 32'd4; src_b = 32'd4; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            nCyc++;
        end
        start = 1'b0;
        chk("t5_latency", 64'(nCyc), 64'd32);
        chk("t5_ignored", {hi, lo}, 64'd4);
        issue(32'd6, 32'd7, 1'b0);
        chk("t5_b2b_state", {62'd0, done, busy}, 64'd1);
        waitDone(nCyc);
        chk("t5_b2b_latency", 64'(nCyc), 64'd32);
        chk("t5_b2b_prod", {hi, lo}, 64'd42);

        // asynchronous reset mid-operation
        @(negedge clk);
        issue(32'd11, 32'd13, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", {62'd0, done, busy}, 64'd0);
        chk("t6_rst_prod", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watchNoDone(40, sawDone);
        chk("t6_no_done", {63'd0, sawDone}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
